// File: rtl/count8_fsm_pkg.sv
// Shared constants and mode encoding for the count8_fsm counter.
// The mode decoder lives here so both the top and any future users agree on priority.
package count8_fsm_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        MODE_CLEAR = 2'd0,
        MODE_LOAD  = 2'd1,
        MODE_COUNT = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    localparam logic [WIDTH_DEF-1:0] CNT_RESET_VAL = '0;

    // Strict priority: reset beats load beats count beats hold.
    function automatic mode_e mode_decode(input logic res, input logic load, input logic en);
        mode_e m;
        if (res) begin
            m = MODE_CLEAR;
        end else if (load) begin
            m = MODE_LOAD;
        end else if (en) begin
            m = MODE_COUNT;
        end else begin
            m = MODE_HOLD;
        end
        return m;
    endfunction

endpackage

// File: rtl/count8_next.sv
// Combinational next-value generator for count8_fsm.
// All increment and wrap behaviour is contained here.
module count8_next
    import count8_fsm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  mode_e            mode_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] cnt_in_i,
    output logic [WIDTH-1:0] nxt_o
);

    always_comb begin
        nxt_o = cnt_i;
        unique case (mode_i)
            MODE_CLEAR: nxt_o = WIDTH'(CNT_RESET_VAL);
            MODE_LOAD:  nxt_o = cnt_in_i;
            // Natural modulo-2^WIDTH wrap; no carry is exported.
            MODE_COUNT: nxt_o = cnt_i + WIDTH'(1);
            MODE_HOLD:  nxt_o = cnt_i;
            default:    nxt_o = cnt_i;
        endcase
    end

endmodule

// File: rtl/count8_fsm.sv
// Loadable up-counter with synchronous active-high reset and clear/load/count/hold priority.
//
//   mode       | meaning
//   MODE_CLEAR | Res=1: counter returns to the reset value
//   MODE_LOAD  | Load=1: counter takes cnt_in
//   MODE_COUNT | En=1: counter increments, wrapping at all-ones
//   MODE_HOLD  | otherwise: counter keeps its value
module count8_fsm
    import count8_fsm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Res,
    input  logic             En,
    input  logic             Load,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt
);

    mode_e            mode_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        mode_d = MODE_HOLD;
        mode_d = mode_decode(Res, Load, En);
    end

    count8_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .mode_i   (mode_d),
        .cnt_i    (cnt_q),
        .cnt_in_i (cnt_in),
        .nxt_o    (cnt_d)
    );

    always_ff @(posedge Clk) begin
        if (Res) begin
            cnt_q <= WIDTH'(CNT_RESET_VAL);
        end else begin
            case (mode_d)
                MODE_CLEAR: cnt_q <= WIDTH'(CNT_RESET_VAL);
                MODE_LOAD:  cnt_q <= cnt_d;
                MODE_COUNT: cnt_q <= cnt_d;
                MODE_HOLD:  cnt_q <= cnt_q;
                default:    cnt_q <= cnt_q;
            endcase
        end
    end

    assign cnt = cnt_q;

endmodule

// File: tb/tb_count8_fsm.sv
// Directed self-checking bench for count8_fsm.
// Expected values are hand-computed constants in each step.
module tb_count8_fsm;

    logic       Clk;
    logic       Res;
    logic       En;
    logic       Load;
    logic [7:0] cnt_in;
    logic [7:0] cnt;

    int n_cmp;
    int n_err;

    count8_fsm #(
        .WIDTH (8)
    ) dut (
        .Clk    (Clk),
        .Res    (Res),
        .En     (En),
        .Load   (Load),
        .cnt_in (cnt_in),
        .cnt    (cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [7:0] exp);
        n_cmp++;
        assert (cnt === exp) else begin
            n_err++;
            $error("FAIL %s: cnt=%h expected %h", tag, cnt, exp);
        end
    endtask

    task automatic tick(input string tag, input logic [7:0] exp);
        @(posedge Clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;

        Res    = 1'b1;
        En     = 1'b1;
        Load   = 1'b1;
        cnt_in = 8'hAA;
        tick("reset0", 8'h00);
        tick("reset1", 8'h00);

        Res  = 1'b0;
        Load = 1'b0;
        En   = 1'b1;
        tick("count1", 8'h01);
        tick("count2", 8'h02);
        tick("count3", 8'h03);
        tick("count4", 8'h04);
        tick("count5", 8'h05);

        Load   = 1'b1;
        cnt_in = 8'h11;
        tick("load0", 8'h11);
        tick("load1", 8'h11);
        Load   = 1'b0;
        cnt_in = 8'h00;
        tick("after_load0", 8'h12);
        tick("after_load1", 8'h13);
        tick("to15_a", 8'h14);
        tick("to15_b", 8'h15);

        En = 1'b0;
        tick("hold0", 8'h15);
        tick("hold1", 8'h15);
        tick("hold2", 8'h15);
        tick("hold3", 8'h15);
        tick("hold4", 8'h15);
        En = 1'b1;
        tick("hold_release", 8'h16);

        Load   = 1'b1;
        En     = 1'b0;
        cnt_in = 8'hFE;
        tick("wrap_load", 8'hFE);
        Load = 1'b0;
        En   = 1'b1;
        tick("wrap_ff", 8'hFF);
        tick("wrap_00", 8'h00);
        tick("wrap_01", 8'h01);

        // Res and Load glitches between edges must not disturb cnt.
        En = 1'b0;
        #2 Res = 1'b1;
        #1 check("res_midcycle", 8'h01);
        Res = 1'b0;
        Load   = 1'b1;
        cnt_in = 8'h77;
        #1 Load = 1'b0;
        check("load_midcycle", 8'h01);
        tick("res_pulse_edge", 8'h01);

        Res    = 1'b1;
        Load   = 1'b1;
        En     = 1'b1;
        cnt_in = 8'h5A;
        tick("res_beats_load", 8'h00);

        Res    = 1'b0;
        Load   = 1'b1;
        En     = 1'b0;
        cnt_in = 8'hC3;
        tick("load_no_en", 8'hC3);

        Load = 1'b0;
        En   = 1'b1;
        tick("count_from_c3", 8'hC4);
        Res = 1'b1;
        tick("res_beats_count", 8'h00);
        Res = 1'b0;
        tick("resume_after_res", 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
